// File: rtl/uart_hex_loader.sv
// Sequences a byte-level UART: assembles ASCII hex digits MSB-first into 32-bit words,
// writes them to instruction memory and returns status characters. Optional echo: LOADER_ECHO_EN.
module uart_hex_loader #(
  parameter int unsigned AW        = 4,
  parameter logic [7:0]  ACK_CHAR  = 8'h2B,
  parameter logic [7:0]  ERR_CHAR  = 8'h3F,
  parameter logic [7:0]  DONE_CHAR = 8'h23
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  output logic          rx_rdy_clr,
  input  logic          tx_busy,
  output logic          tx_wr_en,
  output logic [7:0]    tx_din,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   word_count,
  output logic          load_done,
  output logic          err_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WRITE,
    S_TX_WAIT,
    S_TX_HOLD
  } state_t;

  localparam logic [AW:0] WC_MAX = {1'b1, {AW{1'b0}}};

  state_t      state;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_char;
  logic [31:0] shift;
  logic [3:0]  nib_cnt;
  logic        load_en_q;
`ifdef LOADER_ECHO_EN
  logic        ack_pend;
`endif

  logic        is_hex;
  logic [3:0]  nibble;
  logic [31:0] shifted;
  logic        is_eol;
  logic        restart;

  always_comb begin
    is_hex = 1'b0;
    nibble = '0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0] + 4'd9;
    end
  end

  assign shifted = {shift[27:0], nibble};
  assign is_eol  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign restart = load_en && !load_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rx_byte    <= '0;
      tx_char    <= '0;
      shift      <= '0;
      nib_cnt    <= '0;
      load_en_q  <= 1'b0;
`ifdef LOADER_ECHO_EN
      ack_pend   <= 1'b0;
`endif
      rx_rdy_clr <= 1'b0;
      tx_wr_en   <= 1'b0;
      tx_din     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      rx_rdy_clr <= 1'b0;
      tx_wr_en   <= 1'b0;
      mem_we     <= 1'b0;
      load_en_q  <= load_en;

      case (state)
        S_IDLE: begin
          if (load_en && !load_done && rx_rdy) begin
            rx_byte    <= rx_data;
            rx_rdy_clr <= 1'b1;
            state      <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (is_hex) begin
            shift   <= shifted;
            nib_cnt <= nib_cnt + 4'd1;
            if (nib_cnt == 4'd7) begin
              // Strobe is registered on entry so mem_we is visible during S_WRITE.
              mem_we    <= 1'b1;
              mem_wdata <= shifted;
              state     <= S_WRITE;
`ifdef LOADER_ECHO_EN
              tx_char   <= rx_byte;
              ack_pend  <= 1'b1;
`endif
            end else begin
`ifdef LOADER_ECHO_EN
              tx_char <= rx_byte;
              state   <= S_TX_WAIT;
`else
              state   <= S_IDLE;
`endif
            end
          end else if (is_eol) begin
            if (nib_cnt == 4'd0) begin
              state <= S_IDLE;
            end else begin
              nib_cnt  <= '0;
              err_flag <= 1'b1;
              tx_char  <= ERR_CHAR;
              state    <= S_TX_WAIT;
            end
          end else if (rx_byte == 8'h2E) begin
            nib_cnt   <= '0;
            load_done <= 1'b1;
            tx_char   <= DONE_CHAR;
            state     <= S_TX_WAIT;
          end else begin
            err_flag <= 1'b1;
            tx_char  <= ERR_CHAR;
            state    <= S_TX_WAIT;
          end
        end

        S_WRITE: begin
          mem_addr <= mem_addr + 1'b1;
          if (word_count != WC_MAX) word_count <= word_count + 1'b1;
          nib_cnt  <= '0;
`ifndef LOADER_ECHO_EN
          tx_char  <= ACK_CHAR;
`endif
          state    <= S_TX_WAIT;
        end

        S_TX_WAIT: begin
          if (!tx_busy) begin
            tx_din   <= tx_char;
            tx_wr_en <= 1'b1;
            state    <= S_TX_HOLD;
          end
        end

        S_TX_HOLD: begin
`ifdef LOADER_ECHO_EN
          if (ack_pend) begin
            tx_char  <= ACK_CHAR;
            ack_pend <= 1'b0;
            state    <= S_TX_WAIT;
          end else begin
            state <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end

        default: state <= S_IDLE;
      endcase

      // Restart overrides any same-cycle update from the sequence above.
      if (restart) begin
        load_done  <= 1'b0;
        err_flag   <= 1'b0;
        word_count <= '0;
        mem_addr   <= '0;
        nib_cnt    <= '0;
        shift      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_loader.sv
// Directed bench for uart_hex_loader (default build, AW=2) with a UART receive stub and
// monitors on the memory and transmit strobes.
module tb_uart_hex_loader;

  localparam int unsigned AW = 2;

  logic          clk;
  logic          rst_n;
  logic          load_en;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_rdy_clr;
  logic          tx_busy;
  logic          tx_wr_en;
  logic [7:0]    tx_din;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;
  logic          load_done;
  logic          err_flag;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned we_cnt;
  int unsigned tx_cnt;
  int unsigned clr_cnt;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;
  logic [7:0]    last_tx;

  uart_hex_loader #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .tx_busy    (tx_busy),
    .tx_wr_en   (tx_wr_en),
    .tx_din     (tx_din),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .load_done  (load_done),
    .err_flag   (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      last_addr = mem_addr;
      last_data = mem_wdata;
    end
    if (tx_wr_en) begin
      tx_cnt++;
      last_tx = tx_din;
    end
    if (rx_rdy_clr) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = b;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (rx_rdy_clr) seen = 1'b1;
    end
    rx_rdy = 1'b0;
    if (!seen) check("rx_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      idle(6);
    end
  endtask

  task automatic restart_load;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    load_en = 1'b1;
    idle(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_wr_en"}, {31'd0, tx_wr_en}, 32'd0);
    check({tag, "_tx_din"}, {24'd0, tx_din}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {30'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_word_count"}, {29'd0, word_count}, 32'd0);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_err_flag"}, {31'd0, err_flag}, 32'd0);
    check({tag, "_rx_rdy_clr"}, {31'd0, rx_rdy_clr}, 32'd0);
  endtask

  initial begin
    int unsigned we0, tx0, clr0;
    int clr_at, we_at, tx_at, extra;
    logic cons;

    n_checks = 0; n_fail = 0; we_cnt = 0; tx_cnt = 0; clr_cnt = 0;
    last_addr = '0; last_data = '0; last_tx = '0;
    rst_n = 1'b0; load_en = 1'b0; rx_rdy = 1'b0; rx_data = '0; tx_busy = 1'b0;

    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);
    load_en = 1'b1;
    idle(2);

    // Basic word
    send_str("DEADBEEF");
    check("w1_we_cnt", we_cnt, 32'd1);
    check("w1_addr", {30'd0, last_addr}, 32'd0);
    check("w1_data", last_data, 32'hDEADBEEF);
    check("w1_tx_cnt", tx_cnt, 32'd1);
    check("w1_tx_char", {24'd0, last_tx}, 32'h2B);
    check("w1_word_count", {29'd0, word_count}, 32'd1);
    check("w1_err", {31'd0, err_flag}, 32'd0);

    // Partial word terminated by CR
    restart_load();
    check("rs_word_count", {29'd0, word_count}, 32'd0);
    we0 = we_cnt;
    send_str("12");
    send_byte(8'h0D);
    idle(6);
    check("cr_no_we", we_cnt, we0);
    check("cr_tx_char", {24'd0, last_tx}, 32'h3F);
    check("cr_err", {31'd0, err_flag}, 32'd1);
    send_str("0000000A");
    check("cr_next_addr", {30'd0, last_addr}, 32'd0);
    check("cr_next_data", last_data, 32'h0000000A);

    // Bad character mid-word keeps the partial word
    tx0 = tx_cnt;
    send_str("12g345678");
    check("g_tx_cnt", tx_cnt - tx0, 32'd2);
    check("g_tx_last", {24'd0, last_tx}, 32'h2B);
    check("g_err", {31'd0, err_flag}, 32'd1);
    check("g_addr", {30'd0, last_addr}, 32'd1);
    check("g_data", last_data, 32'h12345678);

    // Address wrap and count saturation
    restart_load();
    check("rs_err_clr", {31'd0, err_flag}, 32'd0);
    send_str("00000001");
    send_str("00000002");
    send_str("00000003");
    send_str("00000004");
    check("sat4_count", {29'd0, word_count}, 32'd4);
    check("sat4_addr", {30'd0, last_addr}, 32'd3);
    send_str("00000005");
    check("sat5_addr", {30'd0, last_addr}, 32'd0);
    check("sat5_data", last_data, 32'd5);
    check("sat5_count", {29'd0, word_count}, 32'd4);

    // Transmitter busy for 100 cycles after the 8th digit
    restart_load();
    send_str("CAFEF00");
    tx0 = tx_cnt;
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = "D"; tx_busy = 1'b1;
    clr_at = -1; we_at = -1; tx_at = -1; extra = 0; cons = 1'b0;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk);
      if (rx_rdy_clr) begin
        if (clr_at < 0) clr_at = i;
        else if (i < 100) extra++;
        else cons = 1'b1;
        rx_rdy = 1'b0;
      end
      if (mem_we && we_at < 0) we_at = i;
      if (tx_wr_en && tx_at < 0) tx_at = i;
      if (i == 3) begin rx_rdy = 1'b1; rx_data = "0"; end
      if (i == 100) tx_busy = 1'b0;
    end
    rx_rdy = 1'b0;
    check("busy_clr_lat", clr_at, 32'd1);
    check("busy_we_lat", we_at, 32'd2);
    check("busy_data", last_data, 32'hCAFEF00D);
    check("busy_tx_held", {31'd0, tx_at > 100}, 32'd1);
    check("busy_no_clr", extra, 32'd0);
    check("busy_pending_taken", {31'd0, cons}, 32'd1);
    check("busy_tx_cnt", tx_cnt - tx0, 32'd1);
    check("busy_tx_char", {24'd0, last_tx}, 32'h2B);

    // End-of-load marker
    send_str(".");
    check("dot_tx_char", {24'd0, last_tx}, 32'h23);
    check("dot_done", {31'd0, load_done}, 32'd1);
    clr0 = clr_cnt;
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = "A";
    idle(20);
    check("dot_not_consumed", clr_cnt, clr0);
    rx_rdy = 1'b0;
    check("dot_word_count", {29'd0, word_count}, 32'd1);
    restart_load();
    check("rs_done_clr", {31'd0, load_done}, 32'd0);
    check("rs_addr_clr", {30'd0, mem_addr}, 32'd0);
    check("rs_count_clr", {29'd0, word_count}, 32'd0);

    // Asynchronous reset while waiting to transmit
    tx_busy = 1'b1;
    tx0 = tx_cnt;
    send_byte("x");
    idle(3);
    check("rst_pre_err", {31'd0, err_flag}, 32'd1);
    check("rst_pre_held", tx_cnt, tx0);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    idle(2);
    rst_n = 1'b1;
    tx_busy = 1'b0;
    idle(3);
    we0 = we_cnt;
    send_str("00000001");
    check("post_rst_we", we_cnt - we0, 32'd1);
    check("post_rst_addr", {30'd0, last_addr}, 32'd0);
    check("post_rst_data", last_data, 32'd1);
    check("post_rst_count", {29'd0, word_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_hex_loader.md
Name: uart_hex_loader

Overview:
- Controller that sequences the byte-level UART core (rdy/rdy_clr receive handshake, wr_en/tx_busy transmit handshake) for instruction loading.
- Parses ASCII hex digits arriving from the PC and assembles them MSB-first into 32-bit words.
- Writes each completed word into instruction memory through a simple write port, and returns status characters over TX.
- Sits between the uart instance and the instruction memory in the top level, replacing ad-hoc echo logic.

Parameters:
- AW, 4, instruction memory address width; depth = 2**AW words
- ACK_CHAR, 8'h2B, character sent after each stored word ('+')
- ERR_CHAR, 8'h3F, character sent on a rejected character or partial word ('?')
- DONE_CHAR, 8'h23, character sent when the end-of-load marker is received ('#')

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_en  in  1  level; loader accepts characters only while high
- rx_rdy  in  1  UART byte-available flag
- rx_data  in  8  UART received byte; valid while rx_rdy is high
- rx_rdy_clr  out  1  one-cycle pulse that clears rx_rdy
- tx_busy  in  1  UART transmitter busy
- tx_wr_en  out  1  one-cycle transmit strobe
- tx_din  out  8  byte to transmit; held stable from the strobe until the next strobe
- mem_we  out  1  one-cycle memory write strobe
- mem_addr  out  AW  write address
- mem_wdata  out  32  write data
- word_count  out  AW+1  number of words stored since reset or restart; saturates at 2**AW
- load_done  out  1  sticky; end-of-load marker received
- err_flag  out  1  sticky; at least one rejected character

Behaviour:
- Reset (async, rst_n low):
  - All outputs are 0; mem_addr=0.
  - Internal nibble counter and shift register are 0; state is S_IDLE.
- States: S_IDLE, S_DECODE, S_WRITE, S_TX_WAIT, S_TX_HOLD.
- S_IDLE:
  - If load_en && !load_done && rx_rdy: capture rx_data and go to S_DECODE.
  - Otherwise stay.
  - A byte that arrives while load_en is low stays pending in the UART; it is not cleared.
- S_DECODE (one cycle): pulse rx_rdy_clr, then classify the captured byte:
  - Hex digit (0x30-0x39, 0x41-0x46, 0x61-0x66):
    - Shift = {shift[27:0], nibble}; nib_cnt++.
    - If nib_cnt reaches 8: go to S_WRITE.
    - Otherwise: go to S_TX_WAIT with the echo byte when LOADER_ECHO_EN is defined, else return to S_IDLE.
  - CR (0x0D) or LF (0x0A):
    - If nib_cnt==0: ignore and go to S_IDLE.
    - Otherwise: discard the partial word (nib_cnt=0), set err_flag, transmit ERR_CHAR.
  - '.' (0x2E): discard any partial word, set load_done, transmit DONE_CHAR.
  - Any other byte: set err_flag, transmit ERR_CHAR; the partial word is kept.
- S_WRITE (one cycle):
  - mem_we=1, mem_wdata=shift, mem_addr=current address.
  - Next cycle: mem_addr increments, wrapping from 2**AW-1 to 0; word_count increments, saturating.
  - nib_cnt=0.
  - Then transmit ACK_CHAR. With LOADER_ECHO_EN, the 8th digit echo is sent first, then ACK_CHAR.
- S_TX_WAIT:
  - Wait until tx_busy==0.
  - Then drive tx_din and pulse tx_wr_en for one cycle, and go to S_TX_HOLD.
- S_TX_HOLD:
  - One cycle in which tx_busy is ignored, to cover the UART busy-rise latency.
  - Then send the next queued character if one exists, else go to S_IDLE.
- Queue depth is at most two characters (echo + ACK). A new rx byte is never consumed while a transmit is pending.
- Latency:
  - rx_rdy high in S_IDLE → rx_rdy_clr at cycle +1.
  - Word-completing digit → mem_we at cycle +2.
  - First tx_wr_en no earlier than cycle +2 (digit/error) or +3 (ACK without echo).
- Restart: a rising edge of load_en clears load_done, err_flag, word_count, mem_addr and nib_cnt.
- load_en falling mid-sequence: the current sequence (write/transmit) completes; then the block idles.
- Only one outstanding strobe at any time: tx_wr_en, mem_we and rx_rdy_clr are never high in the same cycle.

Optional Feature:
- LOADER_ECHO_EN
- Defined: every accepted hex digit is echoed verbatim before any status character.
- Undefined: only ACK_CHAR, ERR_CHAR and DONE_CHAR are transmitted; echo path and second queue slot are removed.

Test Plan:
- load_en=1, send "DEADBEEF" → mem_we once with addr 0, data 32'hDEADBEEF; TX '+' (echo build: "DEADBEEF+"); word_count=1.
- Send "12" then CR → no mem_we; TX '?'; err_flag=1; next "0000000A" stored at addr 0 as 32'h0000000A.
- AW=2, send 5 words → 5th written to addr 0; word_count=4 (saturated).
- Send 'g' mid-word "12g345678" → '?' sent, err_flag=1; word 32'h12345678 still stored.
- Hold tx_busy=1 for 100 cycles after the 8th digit → mem_we still at +2; tx_wr_en held off until tx_busy falls; no rx_rdy_clr while pending.
- Send '.' → TX '#', load_done=1, further bytes not consumed; toggle load_en low→high → load_done=0, mem_addr=0.
- Assert rst_n=0 during S_TX_WAIT → all outputs 0 immediately; after release, "00000001" stored at addr 0.
